// File: rtl/nodf_status_profiler.sv
// -----------------------------------------------------------------------------
// nodf_status_profiler
//
// Per-transaction timing profiler for one non-dataflow HLS module. It watches
// the monitored module's ap_start / ap_done / ap_continue handshake, measures
// latency (done minus start) and start-to-start interval in clock cycles, and
// queues one record per transaction in a first-word-fall-through FIFO that a
// host drains over a valid/ready port.
//
// Parameters
//   CNT_W  width of the free-running cycle counter and of every timing field
//   DEPTH  record FIFO depth (power of two, >= 2)
//
// Ports
//   ap_clk, ap_rst_n     clock (rising edge) and asynchronous active-low reset
//   mon_ap_start         ap_start of the monitored module
//   mon_ap_ready         ap_ready of the monitored module (not used for timing)
//   mon_ap_done          ap_done of the monitored module
//   mon_ap_continue      ap_continue of the monitored module (tie high if absent)
//   finish               end-of-run indication; the profiler stops for good
//   rec_valid/rec_ready  record port handshake; pop on rec_valid && rec_ready
//   rec_latency          done cycle minus start cycle (modulo 2^CNT_W)
//   rec_interval         start cycle minus previous start cycle (0 for first)
//   rec_index            transaction ordinal, from 0
//   rec_incomplete       record was closed by finish rather than by done
//   total_cnt            records generated, dropped ones included
//   drop_cnt             records lost to a full FIFO (saturating)
//   busy                 a transaction is open
// -----------------------------------------------------------------------------
module nodf_status_profiler #(
    parameter int CNT_W = 32,
    parameter int DEPTH = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             mon_ap_start,
    input  logic             mon_ap_ready,
    input  logic             mon_ap_done,
    input  logic             mon_ap_continue,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [CNT_W-1:0] rec_latency,
    output logic [CNT_W-1:0] rec_interval,
    output logic [CNT_W-1:0] rec_index,
    output logic             rec_incomplete,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra pointer bit tells a full FIFO apart from an empty one.
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] latency;
        logic [CNT_W-1:0] interval;
        logic [CNT_W-1:0] index;
        logic             incomplete;
    } rec_t;

    // ap_ready carries no timing information for a non-dataflow module.
    logic unused_ready;
    assign unused_ready = mon_ap_ready;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cyc_q,        cyc_d;
    logic [CNT_W-1:0] start_ts_q,   start_ts_d;
    logic [CNT_W-1:0] prev_ts_q,    prev_ts_d;
    logic             prev_valid_q, prev_valid_d;
    logic [CNT_W-1:0] interval_q,   interval_d;
    logic [CNT_W-1:0] index_q,      index_d;
    logic [CNT_W-1:0] total_q,      total_d;
    logic [CNT_W-1:0] drop_q,       drop_d;
    logic             busy_q,       busy_d;
    logic [PW-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q,     rd_ptr_d;

    rec_t             mem [DEPTH];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic             done_ok;
    logic             fifo_full;
    logic             fifo_pop;
    logic             push;
    logic             push_accept;
    logic [CNT_W-1:0] start_interval;
    rec_t             push_rec;

    assign done_ok   = mon_ap_done && mon_ap_continue;
    assign fifo_full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign fifo_pop  = rec_valid && rec_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d        = state_q;
        cyc_d          = cyc_q + CNT_W'(1);
        start_ts_d     = start_ts_q;
        prev_ts_d      = prev_ts_q;
        prev_valid_d   = prev_valid_q;
        interval_d     = interval_q;
        index_d        = index_q;
        total_d        = total_q;
        drop_d         = drop_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        push           = 1'b0;
        push_accept    = 1'b0;
        push_rec       = '0;
        start_interval = prev_valid_q ? (cyc_q - prev_ts_q) : '0;

        unique case (state_q)
            ST_IDLE: begin
                if (mon_ap_start) begin
                    start_ts_d   = cyc_q;
                    interval_d   = start_interval;
                    prev_ts_d    = cyc_q;
                    prev_valid_d = 1'b1;
                    if (done_ok) begin
                        // Start and completion in the same cycle: the
                        // transaction never becomes visible as busy.
                        push              = 1'b1;
                        push_rec.latency  = '0;
                        push_rec.interval = start_interval;
                        push_rec.index    = index_q;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                if (finish) begin
                    state_d = ST_STOPPED;
                end
            end

            ST_RUN: begin
                if (done_ok) begin
                    push              = 1'b1;
                    push_rec.latency  = cyc_q - start_ts_q;
                    push_rec.interval = interval_q;
                    push_rec.index    = index_q;
                    state_d           = ST_IDLE;
                end else if (finish) begin
                    // Run ended with the transaction still open.
                    push                = 1'b1;
                    push_rec.latency    = cyc_q - start_ts_q;
                    push_rec.interval   = interval_q;
                    push_rec.index      = index_q;
                    push_rec.incomplete = 1'b1;
                end
                if (finish) begin
                    state_d = ST_STOPPED;
                end
            end

            ST_STOPPED: begin
                state_d = ST_STOPPED;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A full FIFO still takes the record when its head leaves this cycle.
        if (push) begin
            total_d = total_q + CNT_W'(1);
            index_d = index_q + CNT_W'(1);
            if (!fifo_full || fifo_pop) begin
                push_accept = 1'b1;
                wr_ptr_d    = wr_ptr_q + PW'(1);
            end else if (drop_q != '1) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end

        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        busy_d = (state_d == ST_RUN);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            start_ts_q   <= '0;
            prev_ts_q    <= '0;
            prev_valid_q <= 1'b0;
            interval_q   <= '0;
            index_q      <= '0;
            total_q      <= '0;
            drop_q       <= '0;
            busy_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of every other flop.
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            start_ts_q   <= start_ts_d;
            prev_ts_q    <= prev_ts_d;
            prev_valid_q <= prev_valid_d;
            interval_q   <= interval_d;
            index_q      <= index_d;
            total_q      <= total_d;
            drop_q       <= drop_d;
            busy_q       <= busy_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // NOTE: the record storage has no reset; its contents only matter when
    // the pointers say an entry is valid, and the outputs are gated below.
    always_ff @(posedge ap_clk) begin
        if (push_accept) begin
            mem[wr_ptr_q[AW-1:0]] <= push_rec;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all driven from flops; no path from the mon_* inputs)
    // -------------------------------------------------------------------------
    rec_t head;

    assign head           = mem[rd_ptr_q[AW-1:0]];
    assign rec_valid      = (wr_ptr_q != rd_ptr_q);
    assign rec_latency    = rec_valid ? head.latency    : '0;
    assign rec_interval   = rec_valid ? head.interval   : '0;
    assign rec_index      = rec_valid ? head.index      : '0;
    assign rec_incomplete = rec_valid ? head.incomplete : 1'b0;
    assign total_cnt      = total_q;
    assign drop_cnt       = drop_q;
    assign busy           = busy_q;

endmodule

// File: doc/nodf_status_profiler.md
# nodf_status_profiler

Synthesizable profiler for one non-dataflow HLS module, such as the insert-sort top function or its sorting sub-instance. It watches the module's ap_start/ap_ready/ap_done/ap_continue handshake and measures per-transaction latency and start-to-start interval in clock cycles. Results go into a small first-word-fall-through record FIFO, which a host or testbench drains over a valid/ready port. It sits beside the monitored module and produces the same per-transaction status that the simulation-side module monitor writes to CSV, so on-board runs and simulation runs can be compared.

## Interface
- CNT_W, 32: width of the cycle counter and of every timing field.
- DEPTH, 16: record FIFO depth; power of two, at least 2.
- ap_clk  in  1  clock; all logic on its rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- mon_ap_start  in  1  ap_start of the monitored module.
- mon_ap_ready  in  1  ap_ready of the monitored module; informational only.
- mon_ap_done  in  1  ap_done of the monitored module.
- mon_ap_continue  in  1  ap_continue of the monitored module; tie to 1 when the module has none.
- finish  in  1  end-of-run indication; sticky once sampled high.
- rec_valid  out  1  FIFO not empty.
- rec_ready  in  1  consumer accepts the head record.
- rec_latency  out  CNT_W  done cycle minus start cycle, modulo 2^CNT_W.
- rec_interval  out  CNT_W  this start cycle minus the previous start cycle; 0 for the first transaction.
- rec_index  out  CNT_W  transaction ordinal, starting at 0.
- rec_incomplete  out  1  record was closed by finish, not by done.
- total_cnt  out  CNT_W  number of records generated, including dropped ones.
- drop_cnt  out  CNT_W  records lost because the FIFO was full; saturates at all-ones.
- busy  out  1  a transaction is open (FSM in RUN).

## Operation
- **Cycle counter:**
  - cyc increments every cycle after reset and wraps.
  - All timing fields are modular differences of cyc.
- **FSM states:** IDLE, RUN, STOPPED.
- **IDLE:**
  - On mon_ap_start=1, capture start_ts=cyc.
  - Interval is cyc-prev_ts, or 0 if no earlier transaction; then set prev_ts=cyc.
  - If mon_ap_done&&mon_ap_continue in the same cycle, push a record with latency 0 and stay in IDLE. Otherwise go to RUN.
- **RUN:**
  - mon_ap_start is ignored.
  - On mon_ap_done&&mon_ap_continue, push latency=cyc-start_ts and return to IDLE.
  - mon_ap_done with mon_ap_continue=0 does not complete the transaction; completion is the first cycle where both are high.
- **finish:**
  - finish=1 in any state moves the FSM to STOPPED; the FSM stays there until reset.
  - If the FSM was in RUN and no done occurs that cycle, push a record with rec_incomplete=1 and latency=cyc-start_ts.
  - If done and finish coincide, the done completion wins: one record with rec_incomplete=0.
  - STOPPED ignores all handshake inputs.
- **Record push:**
  - Every record increments total_cnt and the index counter.
  - If the FIFO is full and no pop happens this cycle, the record is dropped and drop_cnt increments.
  - Push while full with a simultaneous pop (rec_valid&&rec_ready) is accepted.
- **FIFO:**
  - DEPTH entries with first-word-fall-through; the head record drives the rec_* outputs whenever rec_valid=1.
  - Pop on rec_valid&&rec_ready.
  - Read and write pointers are log2(DEPTH)+1 bits wide, so full and empty are distinguished.
- **Reset:**
  - Values: FSM=IDLE, cyc=0, prev_ts invalid, index=0, FIFO empty, rec_valid=0, rec_* fields=0, total_cnt=0, drop_cnt=0, busy=0.
  - Reset asserted mid-transaction discards the open transaction and the FIFO contents.

## Timing
- cyc value "t" means the counter value in the cycle where the event is sampled at the rising edge.
- A record pushed at the edge ending cycle t shows rec_valid=1 in cycle t+1 when the FIFO was empty: 1-cycle latency.
- A pop at the edge ending cycle t makes the next record, or rec_valid=0, visible in cycle t+1.
- busy rises the cycle after start is sampled and falls the cycle after completion.
- busy never rises for a transaction where start and done coincide.
- total_cnt and drop_cnt update in the cycle after the push event.
- No combinational path from the mon_* inputs to any output.
- rec_ready to rec_valid is registered as well.

## Test plan
- **Single transaction:** start high for 1 cycle at cyc=10, done&&continue at cyc=25, rec_ready=1 → one record: latency=15, interval=0, index=0, incomplete=0; total_cnt=1.
- **Back-to-back:** three transactions starting at cyc 10, 30 and 55, each 12 cycles long → intervals 0, 20, 25; latency 12 each; indices 0, 1, 2.
- **Zero-latency and continue hold-off:**
  - start and done&&continue both at cyc=5 → latency=0 and busy stays 0.
  - Start at cyc 8 with done at 20 and continue=0 until cyc 23 → latency=15.
- **FIFO full with DEPTH=4 and rec_ready=0:**
  - Six completed transactions → rec_valid=1, exactly 4 records retained with indices 0 to 3, drop_cnt=2, total_cnt=6.
  - A push coinciding with a pop while full is accepted.
- **finish mid-run:** start at cyc=40, finish at cyc=50 → one record with incomplete=1 and latency=10; a later start/done produces no record.
- **Wrap and reset:**
  - Force cyc near 2^CNT_W-3, start there, done 6 cycles later → latency=6.
  - Assert ap_rst_n=0 while in RUN with 2 records queued → all outputs 0 immediately, FIFO empty.
